// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for the simple dual-port RAM: owns the pointers, occupancy and
// flags, and drives the RAM write/read ports from a push/pop client interface.
module dpram_fifo_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // Client handshake: a push is taken on any edge where wr_en=1 and full=0, a pop
   // on any edge where rd_en=1 and empty=0; requests seen while blocked are dropped
   // (never held) and flagged in the sticky overflow/underflow bits. Popped data
   // appears on rd_data in the cycle after acceptance, qualified by rd_valid.

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          push_ok;
   logic          pop_ok;

   // Pointer MSBs are wrap bits: equal low bits mean full or empty, decided by MSBs.
   assign empty = (wptr == rptr);
   assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                  (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
   assign count = wptr - rptr;

   assign push_ok = wr_en & ~full;
   assign pop_ok  = rd_en & ~empty;

   assign ram_we    = push_ok;
   assign ram_waddr = wptr[ADDR_WIDTH-1:0];
   assign ram_din   = wr_data;
   assign ram_re    = pop_ok;
   assign ram_raddr = rptr[ADDR_WIDTH-1:0];

   assign rd_data = ram_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + PTR_ONE;
         end
         if (pop_ok) begin
            rptr <= rptr + PTR_ONE;
         end
         rd_valid <= pop_ok;
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural registered-read RAM attached
// to its RAM ports; popped data is checked in order against an expected queue.
module tb_dpram_fifo_ctrl;

   localparam int DW = 4;
   localparam int AW = 4;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_din;
   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_dout;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];

   int total = 0;
   int bad   = 0;

   dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .underflow(underflow),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
   );

   // clock / reset and RAM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_din;
      if (reset) ram_dout <= '0;
      else if (ram_re) ram_dout <= mem[ram_raddr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      tick(); tick();
      reset = 1'b0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic push_burst(input int n, input int start);
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b1;
         wr_data = DW'(start + i);
         exp_q.push_back(DW'(start + i));
         tick();
      end
      wr_en = 1'b0;
   endtask

   // pops n words and then one idle cycle, collecting every rd_valid word
   task automatic pop_burst(input int n);
      for (int i = 0; i <= n; i++) begin
         rd_en = (i < n);
         tick();
         if (rd_valid) got_q.push_back(rd_data);
      end
      rd_en = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      do_reset();
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
      total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_sticky got=%b%b exp=00", overflow, underflow); end
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = DW'(i + 1);
         #1;
         total++; if (ram_we !== 1'b1 || ram_waddr !== AW'(i)) begin bad++; $display("FAIL basic_waddr%0d got we=%b addr=%0d exp we=1 addr=%0d", i, ram_we, ram_waddr, i); end
         tick();
      end
      wr_en = 1'b0;
      total++; if (count !== 5'd3) begin bad++; $display("FAIL basic_count3 got=%0d exp=3", count); end
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         #1;
         total++; if (ram_re !== 1'b1 || ram_raddr !== AW'(i)) begin bad++; $display("FAIL basic_raddr%0d got re=%b addr=%0d exp re=1 addr=%0d", i, ram_re, ram_raddr, i); end
         tick();
         total++; if (rd_valid !== 1'b1 || rd_data !== DW'(i + 1)) begin bad++; $display("FAIL basic_rd%0d got valid=%b data=%h exp valid=1 data=%h", i, rd_valid, rd_data, i + 1); end
      end
      rd_en = 1'b0;
      tick();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", rd_valid); end
      total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL basic_end got count=%0d empty=%b exp count=0 empty=1", count, empty); end
   endtask

   task automatic test_full();
      do_reset();
      push_burst(16, 0);
      total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL full_flag got full=%b count=%0d exp full=1 count=16", full, count); end
      wr_en = 1'b1; wr_data = 4'h5;
      #1;
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL full_we_blocked got=%b exp=0", ram_we); end
      tick();
      wr_en = 1'b0;
      total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL full_overflow got ovf=%b count=%0d exp ovf=1 count=16", overflow, count); end
      pop_burst(16);
      total++; if (got_q.size() !== 16) begin bad++; $display("FAIL full_pop_n got=%0d exp=16", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [DW-1:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++; if (g !== e) begin bad++; $display("FAIL full_order got=%h exp=%h", g, e); end
      end
      total++; if (empty !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL full_after got empty=%b ovf=%b exp empty=1 ovf=1", empty, overflow); end
   endtask

   task automatic test_underflow();
      do_reset();
      rd_en = 1'b1;
      #1;
      total++; if (ram_re !== 1'b0) begin bad++; $display("FAIL unf_re_blocked got=%b exp=0", ram_re); end
      tick();
      rd_en = 1'b0;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL unf_no_valid got=%b exp=0", rd_valid); end
      total++; if (underflow !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL unf_flag got unf=%b count=%0d exp unf=1 count=0", underflow, count); end
      tick(); tick();
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
      do_reset();
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_reset_clear got=%b exp=0", underflow); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e;
      do_reset();
      push_burst(5, 1);
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(6 + i);
         exp_q.push_back(DW'(6 + i));
         tick();
         e = exp_q.pop_front();
         total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL b2b_data%0d got valid=%b data=%h exp valid=1 data=%h", i, rd_valid, rd_data, e); end
         total++; if (count !== 5'd5) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=5", i, count); end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      #1;
      // 25 pushes and 20 pops: wptr low bits 9, rptr low bits 4
      total++; if (ram_waddr !== 4'd9 || ram_raddr !== 4'd4) begin bad++; $display("FAIL b2b_wrap got waddr=%0d raddr=%0d exp waddr=9 raddr=4", ram_waddr, ram_raddr); end
      pop_burst(5);
      total++; if (got_q.size() !== 5) begin bad++; $display("FAIL b2b_drain_n got=%0d exp=5", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [DW-1:0] g;
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++; if (g !== e) begin bad++; $display("FAIL b2b_drain got=%h exp=%h", g, e); end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      push_burst(16, 0);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'hA;
      #1;
      total++; if (ram_we !== 1'b0 || ram_re !== 1'b1) begin bad++; $display("FAIL simf_ports got we=%b re=%b exp we=0 re=1", ram_we, ram_re); end
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      total++; if (rd_valid !== 1'b1 || rd_data !== 4'h0) begin bad++; $display("FAIL simf_rd got valid=%b data=%h exp valid=1 data=0", rd_valid, rd_data); end
      total++; if (overflow !== 1'b1 || count !== 5'd15) begin bad++; $display("FAIL simf_state got ovf=%b count=%0d exp ovf=1 count=15", overflow, count); end
      void'(exp_q.pop_front());
      pop_burst(15);
      total++; if (got_q.size() !== 15) begin bad++; $display("FAIL simf_drain_n got=%0d exp=15", got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         logic [DW-1:0] g, e;
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++; if (g !== e) begin bad++; $display("FAIL simf_drain got=%h exp=%h", g, e); end
      end
      total++; if (empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL sime_pre got empty=%b unf=%b exp empty=1 unf=0", empty, underflow); end
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'hA;
      #1;
      total++; if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_din !== 4'hA) begin bad++; $display("FAIL sime_ports got we=%b re=%b din=%h exp we=1 re=0 din=a", ram_we, ram_re, ram_din); end
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      total++; if (underflow !== 1'b1 || count !== 5'd1 || rd_valid !== 1'b0) begin bad++; $display("FAIL sime_state got unf=%b count=%0d valid=%b exp unf=1 count=1 valid=0", underflow, count, rd_valid); end
      pop_burst(1);
      total++; if (got_q.size() !== 1 || got_q[0] !== 4'hA) begin bad++; $display("FAIL sime_data got n=%0d exp n=1 data=a", got_q.size()); end
      got_q.delete();
   endtask

   task automatic test_reset_midop();
      do_reset();
      push_burst(2, 3);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0; reset = 1'b1;
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_inflight got=%b exp=1", rd_valid); end
      tick();
      reset = 1'b0;
      exp_q.delete();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", rd_valid); end
      total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL rst_mid_state got count=%0d empty=%b exp count=0 empty=1", count, empty); end
      wr_en = 1'b1; wr_data = 4'h7;
      #1;
      total++; if (ram_we !== 1'b1 || ram_waddr !== 4'd0) begin bad++; $display("FAIL rst_mid_waddr got we=%b addr=%0d exp we=1 addr=0", ram_we, ram_waddr); end
      tick();
      wr_en = 1'b0;
      total++; if (count !== 5'd1) begin bad++; $display("FAIL rst_mid_count got=%0d exp=1", count); end
   endtask

   // sequence and final report
   initial begin
      reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      test_reset();
      test_basic();
      test_full();
      test_underflow();
      test_back_to_back();
      test_simultaneous();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the write and read ports of the team's simple dual-port RAM (write-only port, read-only port with registered, resettable dout). It owns the pointers, occupancy and flags, and exposes a push/pop interface to the client. Both RAM clocks are tied to this block's clk. This block issues ram_we/ram_waddr/ram_din and ram_re/ram_raddr, and consumes the RAM's registered read data.

Parameters:
DATA_WIDTH, 4, word width; must match the RAM instance.
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries (16 by default).

Ports:
clk  input  1  single clock; also drives both RAM clocks.
reset  input  1  synchronous, active-high reset; also drives the RAM reset.
wr_en  input  1  push request.
wr_data  input  DATA_WIDTH  push data.
rd_en  input  1  pop request.
rd_data  output  DATA_WIDTH  popped data; direct pass-through of ram_dout.
rd_valid  output  1  high for one cycle when rd_data holds a popped word.
full  output  1  occupancy == DEPTH.
empty  output  1  occupancy == 0.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky; set when a push is dropped because the FIFO is full.
underflow  output  1  sticky; set when a pop is dropped because the FIFO is empty.
ram_we  output  1  RAM write enable.
ram_waddr  output  ADDR_WIDTH  RAM write address.
ram_din  output  DATA_WIDTH  RAM write data.
ram_re  output  1  RAM read enable.
ram_raddr  output  ADDR_WIDTH  RAM read address.
ram_dout  input  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset (clk edge with reset=1): wptr=0, rptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0, underflow=0. Reset overrides all requests in the same cycle.
- wptr and rptr are ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits address the RAM. The MSB is a wrap bit.
  - full = (MSBs differ) and (low bits equal).
  - empty = pointers equal.
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - All flags are combinational from the registered pointers.
- Accept rules (combinational):
  - push_ok = wr_en & ~full.
  - pop_ok = rd_en & ~empty.
  - Flags are evaluated on pre-edge state. There is no same-cycle pass-through when full or empty.
- RAM drive (combinational):
  - ram_we = push_ok; ram_waddr = wptr[ADDR_WIDTH-1:0]; ram_din = wr_data.
  - ram_re = pop_ok; ram_raddr = rptr[ADDR_WIDTH-1:0].
- Pointer and count update: on push_ok, wptr+1; on pop_ok, rptr+1. Both in the same cycle leaves count unchanged.
- Pointers wrap naturally: after DEPTH*2 increments they return to 0 with no special case.
- Read latency: rd_valid is registered pop_ok (one cycle after pop accept), and rd_data = ram_dout in that cycle. rd_data is don't-care when rd_valid=0.
- Collision freedom: the write address equals the read address only when full or empty. Writes are blocked when full and reads are blocked when empty, so the RAM never sees a same-cycle read/write to one address.
- Simultaneous events:
  - Full + wr_en + rd_en: the pop is accepted, the push is dropped and overflow is set; count goes DEPTH -> DEPTH-1.
  - Empty + wr_en + rd_en: the push is accepted, the pop is dropped and underflow is set; count goes 0 -> 1.
- overflow and underflow are cleared only by reset.
- Reset mid-operation: the in-flight rd_valid is cleared next cycle and stored data is abandoned (the RAM array is not cleared; the pointers make it unreachable).

Test Plan:
1. Reset, then push 0x1,0x2,0x3 on consecutive cycles, then pop 3 -> ram_waddr 0,1,2; rd_valid pulses one cycle after each pop with rd_data 0x1,0x2,0x3; count 3 -> 0; empty=1 at the end.
2. Push 16 words 0x0..0xF -> full=1, count=16; a 17th push -> ram_we=0, overflow=1; popping 16 returns 0x0..0xF in order.
3. On an empty FIFO assert rd_en -> ram_re=0, no rd_valid, underflow=1; a later reset clears underflow=0.
4. Hold count=5 and assert wr_en+rd_en for 20 cycles with incrementing data -> count stays 5; pointers wrap past 15 -> 0; output order matches input order with 5-cycle FIFO delay.
5. At full, assert wr_en+rd_en with wr_data=0xA -> pop accepted, 0xA not written, overflow=1, count=15. At empty, the same stimulus -> 0xA written, underflow=1, count=1.
6. Pop accepted in cycle N and reset asserted in cycle N+1 -> rd_valid=0 in cycle N+2; count=0, empty=1; the next push writes ram_waddr 0.
